// File: rtl/shifter_pkg.sv
// Shared encodings and width constants for the multi-cycle shift/rotate unit.
// OP codes 101-111 are reserved and leave R and Cr unchanged.
package shifter_pkg;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;

    localparam logic [2:0] OP_SLL = 3'b000;
    localparam logic [2:0] OP_SRL = 3'b001;
    localparam logic [2:0] OP_SRA = 3'b010;
    localparam logic [2:0] OP_RLC = 3'b011;
    localparam logic [2:0] OP_RRC = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// One-position shift/rotate step. The rotates move the bit that is shifted out
// into the carry, and the old carry fills the vacated bit.
module shift_step
    import shifter_pkg::*;
(
    input  logic [DATA_W-1:0] i_r,
    input  logic              i_c,
    input  logic [2:0]        i_op,
    output logic [DATA_W-1:0] o_r,
    output logic              o_c
);

    always_comb begin
        o_r = i_r;
        o_c = i_c;
        case (i_op)
            OP_SLL: begin
                o_c = i_r[DATA_W-1];
                o_r = {i_r[DATA_W-2:0], 1'b0};
            end
            OP_SRL: begin
                o_c = i_r[0];
                o_r = {1'b0, i_r[DATA_W-1:1]};
            end
            OP_SRA: begin
                o_c = i_r[0];
                o_r = {i_r[DATA_W-1], i_r[DATA_W-1:1]};
            end
            OP_RLC: begin
                o_c = i_r[DATA_W-1];
                o_r = {i_r[DATA_W-2:0], i_c};
            end
            OP_RRC: begin
                o_c = i_r[0];
                o_r = {i_c, i_r[DATA_W-1:1]};
            end
            default: begin
                o_r = i_r;
                o_c = i_c;
            end
        endcase
    end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle 8-bit shift/rotate unit: one bit position per clock, with a
// start/busy/done handshake. dbg_state exposes the FSM state for checkers.
module seq_shifter
    import shifter_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] A,
    input  logic              CIN,
    input  logic [2:0]        OP,
    input  logic [AMT_W-1:0]  AMT,
    output logic [DATA_W-1:0] Y,
    output logic              C,
    output logic              busy,
    output logic              done,
    output logic [1:0]        dbg_state
);

    // Handshake: start is accepted only in IDLE. busy stays high from the cycle
    // after accept through the done cycle; done pulses once with Y/C valid.

    state_t             r_state;
    state_t             w_next_state;
    logic [DATA_W-1:0]  r_r;
    logic               r_c;
    logic [AMT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [DATA_W-1:0]  w_step_r;
    logic               w_step_c;

    shift_step u_step (
        .i_r  (r_r),
        .i_c  (r_c),
        .i_op (r_op),
        .o_r  (w_step_r),
        .o_c  (w_step_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = (AMT != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                if (r_cnt == AMT_W'(1)) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    // Outputs decode only the state register, so no input reaches them combinationally.
    always_comb begin
        busy      = (r_state != ST_IDLE);
        done      = (r_state == ST_DONE);
        dbg_state = r_state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_r   <= '0;
            r_c   <= 1'b0;
            r_cnt <= '0;
            r_op  <= OP_SLL;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_r   <= A;
                        r_c   <= CIN;
                        r_cnt <= AMT;
                        r_op  <= OP;
                    end
                end
                ST_SHIFT: begin
                    r_r   <= w_step_r;
                    r_c   <= w_step_c;
                    r_cnt <= r_cnt - AMT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign Y = r_r;
    assign C = r_c;

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle 8-bit shift/rotate unit for the datapath. It performs logical and arithmetic shifts and rotates through carry by 0–7 positions, moving one bit position per clock. Unlike the single-step combinational shifter, it consumes a carry-in and returns it through the rotate ops. It sits beside the ALU and is driven by the control FSM through a start/busy/done handshake.

## Interface
Parameters: none; width is fixed at 8 bits and shift amount at 3 bits.

- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  request; sampled only in IDLE
- A  in  8  operand, captured on accept
- CIN  in  1  carry-in, captured on accept
- OP  in  3  operation, captured on accept: 000 SLL, 001 SRL, 010 SRA, 011 RLC (rotate left through carry), 100 RRC (rotate right through carry), 101–111 reserved
- AMT  in  3  shift count 0–7, captured on accept
- Y  out  8  result register
- C  out  1  carry register
- busy  out  1  high whenever state ≠ IDLE
- done  out  1  one-cycle pulse; Y and C are valid in this cycle

## Operation
- Internal registers:
  - R[7:0] drives Y.
  - Cr drives C.
  - CNT[2:0] is the remaining step count.
  - OPr holds the latched OP.
  - state is IDLE, SHIFT or DONE.
- IDLE: when start=1, load R←A, Cr←CIN, CNT←AMT, OPr←OP. Next state is SHIFT if AMT≠0, else DONE.
- SHIFT: each cycle performs one step and decrements CNT. When CNT=1 the next state is DONE.
- Step rules:
  - SLL: Cr←R[7]; R←{R[6:0],0}
  - SRL: Cr←R[0]; R←{0,R[7:1]}
  - SRA: Cr←R[0]; R←{R[7],R[7:1]}
  - RLC: Cr←R[7]; R←{R[6:0],Cr}
  - RRC: Cr←R[0]; R←{Cr,R[7:1]}
  - reserved ops: R and Cr hold; timing is unchanged.
- DONE: done=1 for one cycle, then go to IDLE.
- Y and C hold their values after DONE until the next accept.
- AMT=0 returns Y=A and C=CIN.
- start while busy (SHIFT or DONE) is ignored. No queueing, no error flag.
- Operand inputs are don't-care except in the accept cycle.

## Timing
- Reset values: state IDLE; R=0x00, Cr=0, CNT=0, OPr=000; Y=0x00, C=0, busy=0, done=0.
- Reset mid-operation aborts in the same edge. No done pulse is issued, and Y/C return to 0.
- If start is sampled high in cycle k:
  - busy is high in cycles k+1 … k+AMT+1.
  - done is high in cycle k+AMT+1 only.
  - The earliest next accept is a start high in cycle k+AMT+2 (IDLE again).
- Y and C change only on accept, on SHIFT edges, and on reset.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package shifter_pkg holds:
  - OP encodings (OP_SLL, OP_SRL, OP_SRA, OP_RLC, OP_RRC)
  - the state enum (ST_IDLE, ST_SHIFT, ST_DONE)
  - width constants (DATA_W=8, AMT_W=3)
- One combinational sub-module, shift_step. It takes R, Cr and OPr and produces the next R and Cr per the step rules. Reserved ops pass through unchanged.
- The top level holds the FSM, the counter and the registers, and instantiates shift_step once.

## Test plan
- SLL, A=0x81, AMT=1, start in cycle k → done in k+2; Y=0x02, C=1.
- SRA, A=0x80, AMT=3 → done in k+4; Y=0xF0, C=0. SRL, A=0xFF, AMT=7 → done in k+8; Y=0x01, C=1.
- RLC, A=0x80, CIN=0, AMT=2 → Y=0x01, C=0. RRC, A=0x01, CIN=1, AMT=1 → Y=0x80, C=1.
- AMT=0, SRL, A=0x5A, CIN=1 → done in k+1; Y=0x5A, C=1; busy high for exactly one cycle.
- SLL, A=0x01, AMT=4; pulse start again with A=0xFF at k+2 → the second start is ignored; Y=0x10, C=0; only one done pulse.
- SRL, A=0xF0, AMT=5; rst=1 at k+2 → next cycle busy=0, Y=0x00, C=0; no done pulse. A new start after reset completes normally.
